// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, default panel timing and colour helpers for the LCD text controller.
package lcd_pkg;

  // Default 480x272 panel timing, in pixel clocks / lines.
  localparam int unsigned DefHActive = 480;
  localparam int unsigned DefHFp     = 5;
  localparam int unsigned DefHSync   = 1;
  localparam int unsigned DefHBp     = 43;
  localparam int unsigned DefVActive = 272;
  localparam int unsigned DefVFp     = 8;
  localparam int unsigned DefVSync   = 1;
  localparam int unsigned DefVBp     = 12;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t rgb565_split(input logic [15:0] color);
    rgb565_t c;
    c.r = color[15:11];
    c.g = color[10:5];
    c.b = color[4:0];
    return c;
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if: read bus from the text controller to the text BSRAM and font ROM.
// Both memories return data one clock after the address is presented.
interface lcd_text_ctrl_if #(
  parameter int unsigned VADDR_W = 10,
  parameter int unsigned FADDR_W = 12
);
  logic [VADDR_W-1:0] vram_addr;
  logic [7:0]         vram_data;
  logic [FADDR_W-1:0] font_addr;
  logic [7:0]         font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_data,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_data,
    output font_data
  );
endinterface

// File: rtl/lcd_timing.sv
// lcd_timing: free-running H/V counters and the per-pixel region flags derived from them.
// Line and frame order is sync, back porch, active, front porch.
module lcd_timing
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
  localparam int unsigned HCNT_W  = $clog2(H_TOTAL),
  localparam int unsigned VCNT_W  = $clog2(V_TOTAL)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [HCNT_W-1:0] x_o,
  output logic [VCNT_W-1:0] y_o,
  output logic              active_o,
  output logic              hsync_o,        // high inside the HSYNC interval
  output logic              vsync_o,        // high inside the VSYNC interval
  output logic              frame_first_o,  // counter state (0,0)
  output logic              frame_last_o    // final counter state of the frame
);
  localparam int unsigned HStart = H_SYNC + H_BP;
  localparam int unsigned VStart = V_SYNC + V_BP;

  logic [HCNT_W-1:0] hcnt_d, hcnt_q;
  logic [VCNT_W-1:0] vcnt_d, vcnt_q;
  logic              h_last, v_last;

  assign h_last = (hcnt_q == HCNT_W'(H_TOTAL - 1));
  assign v_last = (vcnt_q == VCNT_W'(V_TOTAL - 1));

  // Next counter state: step along the line, wrap into the next line, then the next frame.
  always_comb begin
    hcnt_d = hcnt_q + HCNT_W'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + VCNT_W'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign x_o           = hcnt_q - HCNT_W'(HStart);
  assign y_o           = vcnt_q - VCNT_W'(VStart);
  assign active_o      = (hcnt_q >= HCNT_W'(HStart)) && (hcnt_q < HCNT_W'(HStart + H_ACTIVE)) &&
                         (vcnt_q >= VCNT_W'(VStart)) && (vcnt_q < VCNT_W'(VStart + V_ACTIVE));
  assign hsync_o       = (hcnt_q < HCNT_W'(H_SYNC));
  assign vsync_o       = (vcnt_q < VCNT_W'(V_SYNC));
  assign frame_first_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign frame_last_o  = h_last && v_last;

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: text-mode RGB565 panel controller. Counter state -> text BSRAM -> font ROM ->
// registered pixel, three clocks end to end; timing flags ride the same pipeline.
// Optional blinking block cursor when LCD_CURSOR_EN is defined.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DefHActive,
  parameter int unsigned H_FP         = DefHFp,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_BP         = DefHBp,
  parameter int unsigned V_ACTIVE     = DefVActive,
  parameter int unsigned V_FP         = DefVFp,
  parameter int unsigned V_SYNC       = DefVSync,
  parameter int unsigned V_BP         = DefVBp,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned BLINK_FRAMES = 32,
  localparam int unsigned COLS    = H_ACTIVE / CHAR_W,
  localparam int unsigned ROWS    = V_ACTIVE / CHAR_H,
  localparam int unsigned VADDR_W = $clog2(COLS * ROWS),
  localparam int unsigned LINE_W  = $clog2(CHAR_H),
  localparam int unsigned COL_W   = $clog2(COLS),
  localparam int unsigned ROW_W   = $clog2(ROWS)
) (
  input  logic                  PixelClk,
  input  logic                  nRST,
  lcd_text_ctrl_if.master       mem,
  input  logic [15:0]           fg_color,
  input  logic [15:0]           bg_color,
  input  logic [COL_W-1:0]      cursor_col,
  input  logic [ROW_W-1:0]      cursor_row,
  output logic                  LCD_DE,
  output logic                  LCD_HSYNC,
  output logic                  LCD_VSYNC,
  output logic [4:0]            LCD_R,
  output logic [5:0]            LCD_G,
  output logic [4:0]            LCD_B,
  output logic                  frame_start
);
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HCNT_W  = $clog2(H_TOTAL);
  localparam int unsigned VCNT_W  = $clog2(V_TOTAL);
  localparam int unsigned PIX_W   = $clog2(CHAR_W);

  // Stage 0: counter state.
  logic [HCNT_W-1:0] x0, col0;
  logic [VCNT_W-1:0] y0, row0;
  logic              act0, hs0, vs0, fs0, fl0, cur0;

  // Stage 1: character code returning from the text buffer.
  logic              act1_q, hs1_q, vs1_q, fs1_q, cur1_q;
  logic [PIX_W-1:0]  pix1_q;
  logic [LINE_W-1:0] line1_q;

  // Stage 2: glyph row returning from the font ROM.
  logic              act2_q, hs2_q, vs2_q, fs2_q, cur2_q;
  logic [PIX_W-1:0]  pix2_q;

  logic              glyph_bit;
  logic [15:0]       pixel;
  rgb565_t           rgb;

  lcd_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (PixelClk),
    .rst_ni        (nRST),
    .x_o           (x0),
    .y_o           (y0),
    .active_o      (act0),
    .hsync_o       (hs0),
    .vsync_o       (vs0),
    .frame_first_o (fs0),
    .frame_last_o  (fl0)
  );

  assign col0 = x0 / HCNT_W'(CHAR_W);
  assign row0 = y0 / VCNT_W'(CHAR_H);

  // Address is parked at 0 during blanking so the BSRAM sees no stray out-of-range reads.
  assign mem.vram_addr = act0 ? VADDR_W'(32'(row0) * COLS + 32'(col0)) : '0;
  assign mem.font_addr = {mem.vram_data, line1_q};

`ifdef LCD_CURSOR_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_on_q;

  // Blink phase: advances as each frame ends, flips every BLINK_FRAMES frames, starts visible.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (fl0) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Out-of-range cursor coordinates can never match a visible cell.
  assign cur0 = blink_on_q && (col0 == HCNT_W'(cursor_col)) && (row0 == VCNT_W'(cursor_row));
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row, fl0, BLINK_FRAMES[0]};
  assign cur0          = 1'b0;
`endif

  // Fetch pipeline: keep the flags aligned with the memory read latency.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      {act1_q, hs1_q, vs1_q, fs1_q, cur1_q} <= '0;
      pix1_q  <= '0;
      line1_q <= '0;
      {act2_q, hs2_q, vs2_q, fs2_q, cur2_q} <= '0;
      pix2_q  <= '0;
    end else begin
      {act1_q, hs1_q, vs1_q, fs1_q, cur1_q} <= {act0, hs0, vs0, fs0, cur0};
      pix1_q  <= x0[PIX_W-1:0];
      line1_q <= y0[LINE_W-1:0];
      {act2_q, hs2_q, vs2_q, fs2_q, cur2_q} <= {act1_q, hs1_q, vs1_q, fs1_q, cur1_q};
      pix2_q  <= pix1_q;
    end
  end

  // Pixel mux: bit7 of the glyph row is the leftmost pixel; the cursor swaps fg and bg.
  always_comb begin
    glyph_bit = mem.font_data[PIX_W'(CHAR_W - 1) - pix2_q];
    pixel     = 16'h0000;
    if (act2_q) begin
      pixel = (glyph_bit ^ cur2_q) ? fg_color : bg_color;
    end
    rgb = rgb565_split(pixel);
  end

  // Registered panel outputs; sync pins are active low.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= 1'b1;
      LCD_VSYNC   <= 1'b1;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      LCD_DE      <= act2_q;
      LCD_HSYNC   <= ~hs2_q;
      LCD_VSYNC   <= ~vs2_q;
      LCD_R       <= rgb.r;
      LCD_G       <= rgb.g;
      LCD_B       <= rgb.b;
      frame_start <= fs2_q;
    end
  end

endmodule
